// File: rtl/commit_trace_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_ctrl
// Purpose  : Buffers retired-instruction commits in a small FIFO and
//            serialises them to the trace consumer, with ebreak halt
//            sequencing, instruction/cycle counters and a no-commit watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65536,
  parameter int TMO_W   = 17
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmt_valid,
  input  logic [63:0] cmt_pc,
  input  logic [31:0] cmt_inst,
  input  logic        cmt_break,
  output logic        cmt_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_break,
  output logic        halt,
  output logic        timeout,
  output logic [63:0] inst_cnt,
  output logic [63:0] cycle_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TMO_W-1:0] WD_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2,
    S_TMO   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [63:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic        brk_mem  [DEPTH];

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic [TMO_W-1:0] wd;
  logic             full, empty, enq, deq, accept_run;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign enq   = cmt_valid && cmt_ready;
  assign deq   = out_valid && out_ready;

  // Local accept term keeps the FSM block free of a loop through cmt_ready.
  assign accept_run = cmt_valid && !full;

  always_comb begin
    count_nxt = count;
    if (enq && !deq) begin
      count_nxt = count + 1'b1;
    end else if (!enq && deq) begin
      count_nxt = count - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cmt_ready = 1'b0;
    case (state)
      S_RUN: begin
        cmt_ready = !full;
        if (accept_run && cmt_break) begin
          state_nxt = S_DRAIN;
        end else if (!accept_run && (wd == WD_LAST)) begin
          state_nxt = S_TMO;
        end
      end
      S_DRAIN: begin
        if (count_nxt == '0) begin
          state_nxt = S_HALT;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      S_TMO:   state_nxt = S_TMO;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wd        <= '0;
      inst_cnt  <= '0;
      cycle_cnt <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (enq) begin
        wr_ptr   <= wr_ptr + 1'b1;
        inst_cnt <= inst_cnt + 64'd1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (enq) begin
        wd <= '0;
      end else if (state == S_RUN) begin
        wd <= wd + 1'b1;
      end
      if ((state == S_RUN) || (state == S_DRAIN)) begin
        cycle_cnt <= cycle_cnt + 64'd1;
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clock) begin
    if (enq) begin
      pc_mem[wr_ptr]   <= cmt_pc;
      inst_mem[wr_ptr] <= cmt_inst;
      brk_mem[wr_ptr]  <= cmt_break;
    end
  end

  assign out_valid = !empty;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]   : 64'd0;
  assign out_inst  = out_valid ? inst_mem[rd_ptr] : 32'd0;
  assign out_break = out_valid ? brk_mem[rd_ptr]  : 1'b0;
  assign halt      = (state == S_HALT);
  assign timeout   = (state == S_TMO);

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_ctrl
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int TMO_W   = 17;

  logic        clock = 1'b0;
  logic        reset, cmt_valid, cmt_break, out_ready;
  logic [63:0] cmt_pc;
  logic [31:0] cmt_inst;
  logic        cmt_ready, out_valid, out_break, halt, timeout;
  logic [63:0] out_pc, inst_cnt, cycle_cnt;
  logic [31:0] out_inst;

  commit_trace_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
    .clock(clock), .reset(reset),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst),
    .cmt_break(cmt_break), .cmt_ready(cmt_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_break(out_break),
    .halt(halt), .timeout(timeout), .inst_cnt(inst_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the trace stream as a queue plus a few behavioural flags.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        brk;
  } ent_t;

  ent_t        q[$];
  bit          m_brk, m_halt, m_tmo;
  int          m_idle;
  logic [63:0] m_inst, m_cyc;

  task automatic model_edge();
    bit running, acc, dq, was_drain;
    if (reset) begin
      q.delete();
      m_brk = 0; m_halt = 0; m_tmo = 0; m_idle = 0;
      m_inst = 0; m_cyc = 0;
      return;
    end
    running   = !m_brk && !m_tmo;
    acc       = cmt_valid && running && (q.size() < DEPTH);
    dq        = (q.size() > 0) && out_ready;
    was_drain = m_brk && !m_halt;
    if (!m_halt && !m_tmo) m_cyc++;
    if (dq) void'(q.pop_front());
    if (acc) begin
      q.push_back('{pc: cmt_pc, inst: cmt_inst, brk: cmt_break});
      m_inst++;
      m_idle = 0;
      if (cmt_break) m_brk = 1;
    end else if (running) begin
      if (m_idle == TIMEOUT - 1) m_tmo = 1;
      else m_idle++;
    end
    if (was_drain && q.size() == 0) m_halt = 1;
  endtask

  task automatic check_model();
    bit ne;
    ne = q.size() > 0;
    chk("m_cmt_ready", 64'(cmt_ready), 64'(!m_brk && !m_tmo && q.size() < DEPTH));
    chk("m_out_valid", 64'(out_valid), 64'(ne));
    chk("m_out_pc",    out_pc,          ne ? q[0].pc : 64'd0);
    chk("m_out_inst",  64'(out_inst),   ne ? 64'(q[0].inst) : 64'd0);
    chk("m_out_break", 64'(out_break),  ne ? 64'(q[0].brk) : 64'd0);
    chk("m_halt",      64'(halt),       64'(m_halt));
    chk("m_timeout",   64'(timeout),    64'(m_tmo));
    chk("m_inst_cnt",  inst_cnt,        m_inst);
    chk("m_cycle_cnt", cycle_cnt,       m_cyc);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1; cmt_valid = 0; cmt_break = 0; out_ready = 0;
    step();
    reset = 0;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic b, input logic rdy);
    cmt_valid = v; cmt_pc = pc; cmt_inst = pc[31:0] ^ 32'h0010_0073; cmt_break = b; out_ready = rdy;
  endtask

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic        rdy;
    logic        e_ready;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_icnt;
    logic [63:0] e_ccnt;
  } vec_t;

  vec_t tv[4];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dlv;
    logic lbrk;
    int vprob;

    tv[0] = '{1'b1, 64'h8000_0000, 1'b1, 1'b1, 1'b1, 64'h8000_0000, 64'd1, 64'd1};
    tv[1] = '{1'b1, 64'h8000_0004, 1'b1, 1'b1, 1'b1, 64'h8000_0004, 64'd2, 64'd2};
    tv[2] = '{1'b1, 64'h8000_0008, 1'b1, 1'b1, 1'b1, 64'h8000_0008, 64'd3, 64'd3};
    tv[3] = '{1'b0, 64'h0,         1'b1, 1'b1, 1'b0, 64'h0,         64'd3, 64'd4};

    reset = 1; cmt_valid = 0; cmt_pc = 0; cmt_inst = 0; cmt_break = 0; out_ready = 0;
    do_reset();
    chk("rst_cmt_ready", 64'(cmt_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_counters", inst_cnt | cycle_cnt, 64'd0);

    // Back-to-back commits with a consumer always ready
    for (int i = 0; i < 4; i++) begin
      drive(tv[i].v, tv[i].pc, 1'b0, tv[i].rdy);
      step();
      chk($sformatf("t1_ready_%0d", i), 64'(cmt_ready), 64'(tv[i].e_ready));
      chk($sformatf("t1_valid_%0d", i), 64'(out_valid), 64'(tv[i].e_valid));
      chk($sformatf("t1_pc_%0d", i),    out_pc,          tv[i].e_pc);
      chk($sformatf("t1_icnt_%0d", i),  inst_cnt,        tv[i].e_icnt);
      chk($sformatf("t1_ccnt_%0d", i),  cycle_cnt,       tv[i].e_ccnt);
    end

    // Fill with a stalled consumer, then drain
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0);
      step();
      if (i == 3) chk("t2_full_ready", 64'(cmt_ready), 64'd0);
    end
    chk("t2_head_stable", out_pc, 64'h8000_0000);
    chk("t2_icnt", inst_cnt, 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_drain_pc_%0d", i), out_pc, 64'h8000_0000 + 64'(4 * i));
      drive(1'b0, 64'h0, 1'b0, 1'b1);
      step();
    end
    chk("t2_empty", 64'(out_valid), 64'd0);
    chk("t2_ready_back", 64'(cmt_ready), 64'd1);

    // ebreak with two entries queued
    do_reset();
    drive(1'b1, 64'h8000_0008, 1'b0, 1'b0); step();
    drive(1'b1, 64'h8000_000C, 1'b0, 1'b0); step();
    drive(1'b1, 64'h8000_0010, 1'b1, 1'b1);
    dlv = 0; lbrk = 0;
    if (out_valid && out_ready) begin dlv++; lbrk = out_break; end
    step();
    chk("t3_ready_after_ebreak", 64'(cmt_ready), 64'd0);
    drive(1'b1, 64'h9999_0000, 1'b0, 1'b1);
    for (int i = 0; i < 10 && !halt; i++) begin
      if (out_valid && out_ready) begin dlv++; lbrk = out_break; end
      step();
    end
    chk("t3_halt", 64'(halt), 64'd1);
    chk("t3_delivered", 64'(dlv), 64'd3);
    chk("t3_last_break", 64'(lbrk), 64'd1);
    for (int i = 0; i < 3; i++) step();
    chk("t3_cycle_frozen", cycle_cnt, 64'd5);
    chk("t3_icnt", inst_cnt, 64'd3);
    chk("t3_halt_sticky", 64'(halt), 64'd1);

    // Watchdog
    do_reset();
    drive(1'b1, 64'h8000_0020, 1'b0, 1'b0); step();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) chk("t4_no_timeout_yet", 64'(timeout), 64'd0);
    end
    chk("t4_timeout", 64'(timeout), 64'd1);
    chk("t4_ready", 64'(cmt_ready), 64'd0);
    chk("t4_pending_pc", out_pc, 64'h8000_0020);
    drive(1'b1, 64'h1234, 1'b0, 1'b1); step();
    chk("t4_delivered", 64'(out_valid), 64'd0);
    chk("t4_icnt", inst_cnt, 64'd1);

    // Simultaneous enqueue/dequeue at occupancy 1
    do_reset();
    drive(1'b1, 64'h8000_0100, 1'b0, 1'b0); step();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 64'h8000_0100 + 64'(4 * i), 1'b0, 1'b1);
      step();
      chk($sformatf("t5_head_%0d", i), out_pc, 64'h8000_0100 + 64'(4 * i));
      chk($sformatf("t5_valid_%0d", i), 64'(out_valid), 64'd1);
    end
    chk("t5_icnt", inst_cnt, 64'd11);

    // Reset while draining
    do_reset();
    drive(1'b1, 64'h8000_0200, 1'b0, 1'b0); step();
    drive(1'b1, 64'h8000_0204, 1'b1, 1'b0); step();
    chk("t6_in_drain", 64'(cmt_ready), 64'd0);
    reset = 1; drive(1'b0, 64'h0, 1'b0, 1'b0); step(); reset = 0;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_ready", 64'(cmt_ready), 64'd1);
    chk("t6_halt", 64'(halt), 64'd0);
    chk("t6_counters", inst_cnt | cycle_cnt, 64'd0);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      vprob = ((k / 200) % 3 == 0) ? 2 : 7;
      reset = ($urandom_range(0, 299) == 0) ||
              ((m_halt || m_tmo) && $urandom_range(0, 7) == 0);
      drive($urandom_range(0, 9) < vprob, {$urandom, $urandom},
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6);
      step();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
